// File: rtl/ps2_defs_pkg.sv
// Shared PS/2 definitions: receiver FSM encoding, prefix bytes and the scan
// codes the downstream keyboard command decoder looks for.
package ps2_defs;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_SPACE = 8'h29;

    // PS/2 frames use odd parity over the 8 data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Synchronizes a raw PS/2 line, deglitches it, and pulses on filtered falls.
// Filtered level lags the raw line by 2 + FILTER_LEN cycles; no backpressure.
module ps2_input_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic filt_o,
    output logic fall_o
);

    localparam int CNT_W = 4;

    logic             sync1_q, sync2_q;
    logic             filt_q, filt_d;
    logic             filt_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts consecutive synchronized samples that disagree with the filtered level.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= raw_i;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            cnt_q       <= cnt_d;
        end
    end

    assign filt_o = filt_q;
    assign fall_o = filt_prev_q & ~filt_q;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 keyboard frame receiver: deserializes 11-bit frames, folds F0/E0 prefixes.
// Code/error strobes 1 cycle after the stop-bit fall; no backpressure (strobes are lossy).
module ps2_frame_receiver
    import ps2_defs::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] oScanCode,
    output logic       oCodeValid,
    output logic       oBreak,
    output logic       oExtended,
    output logic       oParityError,
    output logic       oFrameError
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic             clk_filt, fall;
    logic             data_s1_q, data_s_q;
    ps2_state_e       state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             brk_q, brk_d, ext_q, ext_d;
    logic [7:0]       code_q, code_d;
    logic             vld_q, vld_d, obrk_q, obrk_d, oext_q, oext_d;
    logic             perr_q, perr_d, ferr_q, ferr_d;
    logic             timeout;

    ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_i  (Clock),
        .rst_i  (Reset),
        .raw_i  (PS2_CLK),
        .filt_o (clk_filt),
        .fall_o (fall)
    );

    assign timeout = (state_q != ST_IDLE) && !fall && (tmo_q == TMO_W'(TIMEOUT_CYCLES));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = ST_IDLE;
        end else if (fall) begin
            case (state_q)
                ST_IDLE:   if (!data_s_q) state_d = ST_DATA;
                ST_DATA:   if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_d     = (state_q == ST_IDLE || fall || timeout) ? '0 : tmo_q + TMO_W'(1);
        brk_d     = brk_q;
        ext_d     = ext_q;
        code_d    = code_q;
        vld_d     = 1'b0;
        obrk_d    = obrk_q;
        oext_d    = oext_q;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        if (timeout) begin
            ferr_d = 1'b1;
            brk_d  = 1'b0;
            ext_d  = 1'b0;
        end else if (fall) begin
            case (state_q)
                ST_IDLE:   bit_cnt_d = 3'd0;
                ST_DATA: begin
                    shift_d   = {data_s_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                ST_PARITY: par_d = data_s_q;
                ST_STOP: begin
                    if (!data_s_q) begin
                        ferr_d = 1'b1;
                        brk_d  = 1'b0;
                        ext_d  = 1'b0;
                    end else if (!odd_parity_ok(shift_q, par_q)) begin
                        perr_d = 1'b1;
                        brk_d  = 1'b0;
                        ext_d  = 1'b0;
                    end else if (shift_q == BREAK_CODE) begin
                        brk_d = 1'b1;
                    end else if (shift_q == EXT_CODE) begin
                        ext_d = 1'b1;
                    end else begin
                        code_d = shift_q;
                        vld_d  = 1'b1;
                        obrk_d = brk_q;
                        oext_d = ext_q;
                        brk_d  = 1'b0;
                        ext_d  = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            data_s1_q <= 1'b1;
            data_s_q  <= 1'b1;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
            code_q    <= '0;
            vld_q     <= 1'b0;
            obrk_q    <= 1'b0;
            oext_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            data_s1_q <= PS2_DATA;
            data_s_q  <= data_s1_q;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            brk_q     <= brk_d;
            ext_q     <= ext_d;
            code_q    <= code_d;
            vld_q     <= vld_d;
            obrk_q    <= obrk_d;
            oext_q    <= oext_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign oScanCode    = code_q;
    assign oCodeValid   = vld_q;
    assign oBreak       = obrk_q;
    assign oExtended    = oext_q;
    assign oParityError = perr_q;
    assign oFrameError  = ferr_q;

endmodule

// File: doc/ps2_frame_receiver.md
Name: ps2_frame_receiver

Overview:
Synchronous PS/2 keyboard frame receiver running in the system clock domain. It is the stage directly upstream of the keyboard command decoder. It synchronizes and deglitches PS2_CLK/PS2_DATA, deserializes 11-bit frames, and checks parity and stop bit. It folds F0 (break) and E0 (extended) prefixes into flags and emits one clean scan code per key event as a single-cycle strobe.

Parameters:
FILTER_LEN, 4, consecutive identical samples required before the filtered PS2_CLK level changes (range 2..15)
TIMEOUT_CYCLES, 50000, Clock cycles without a falling PS2_CLK edge before a partial frame is aborted (1 ms at 50 MHz)

Ports:
Clock  in  1  system clock (50 MHz)
Reset  in  1  asynchronous, active-high reset
PS2_CLK  in  1  raw keyboard clock, asynchronous
PS2_DATA  in  1  raw keyboard data, asynchronous
oScanCode  out  8  last decoded scan code; holds until next oCodeValid
oCodeValid  out  1  one-cycle strobe: oScanCode/oBreak/oExtended valid
oBreak  out  1  current code was preceded by F0 (key release)
oExtended  out  1  current code was preceded by E0
oParityError  out  1  one-cycle strobe: frame dropped, odd parity failed
oFrameError  out  1  one-cycle strobe: frame dropped, bad stop bit or timeout

Behaviour:
- Interface: one clock (Clock); Reset is asynchronous and active-high.
- Reset values: all outputs 0, filtered clock = 1, FSM = IDLE, prefix flags 0, bit counter 0, timeout counter 0.
- Input conditioning:
  - Both inputs pass through a 2-FF synchronizer.
  - PS2_CLK then passes a glitch filter: the filtered level flips only after FILTER_LEN consecutive synchronized samples differ from it.
  - fall_pulse is 1 for exactly one cycle on a 1->0 transition of the filtered level.
  - Data is sampled (synchronized value) in the fall_pulse cycle.
- FSM, all transitions on fall_pulse unless noted:
  - IDLE: data=0 -> DATA with bit counter 0; data=1 -> stay in IDLE (spurious edge ignored).
  - DATA: shift right into an 8-bit buffer (LSB first, new bit enters at MSB). After the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: resolve the frame, then go to IDLE in the same transition:
    - stop=0 -> frame error;
    - otherwise, XOR of 8 data bits and parity != 1 -> parity error;
    - otherwise -> good byte.
- Good byte handling:
  - 8'hF0: set break flag, no strobe.
  - 8'hE0: set extended flag, no strobe.
  - Any other byte: in the next cycle, oScanCode = byte, oBreak/oExtended = flags, oCodeValid = 1 for one cycle. Flags clear in that same cycle.
- Latency: oCodeValid rises exactly 1 Clock cycle after the fall_pulse that samples the stop bit.
- Error strobes: fire 1 cycle after the detecting fall_pulse, for one cycle. Prefix flags clear. oScanCode is unchanged.
- Timeout:
  - The counter runs only outside IDLE and resets on every fall_pulse.
  - On reaching TIMEOUT_CYCLES: FSM -> IDLE, oFrameError pulses one cycle, prefix flags clear.
  - In IDLE the counter is held at 0.
- Prefix sequences:
  - Consecutive prefixes accumulate (E0,F0 sets both).
  - A repeated F0 before a data byte leaves break=1.
- Flag and output timing:
  - oBreak/oExtended change only together with oCodeValid or on reset.
  - They hold their values between strobes.
- Reset mid-frame: returns immediately to reset values. A partial frame is discarded without an error strobe.
- A held-low PS2_DATA in IDLE restarts a frame on each fall_pulse. This is acceptable.
- Host-to-device transmission is out of scope; PS2_CLK/PS2_DATA are inputs only.

Decomposition:
- Shared package ps2_defs:
  - FSM state encoding (IDLE, DATA, PARITY, STOP);
  - prefix constants BREAK_CODE=8'hF0, EXT_CODE=8'hE0;
  - key constants used by the decoder: W=8'h1D, S=8'h1B, A=8'h1C, D=8'h23, SPACE=8'h29.
- One sub-module: ps2_input_filter (2-FF synchronizer + FILTER_LEN glitch filter + falling-edge pulse), instantiated for PS2_CLK. PS2_DATA uses only a 2-FF synchronizer.

Test Plan:
- Frame 0x1D, parity 1, stop 1, bit period 40 us -> one oCodeValid pulse, oScanCode=8'h1D, oBreak=0, oExtended=0, exactly 1 cycle after the stop-bit fall_pulse.
- Frames F0 then 1D -> no strobe after F0; single strobe with oScanCode=8'h1D, oBreak=1. Subsequent frame 1D -> oBreak=0.
- Frames E0, F0, 75 -> single strobe, oScanCode=8'h75, oExtended=1, oBreak=1. Flags clear afterwards.
- Frame 0x1C with parity bit 1 (wrong) -> oParityError one-cycle pulse, no oCodeValid, oScanCode keeps its previous value. Next valid frame 0x29 -> strobe with 8'h29.
- Start + 5 data bits, then idle for TIMEOUT_CYCLES+10 -> oFrameError pulse, FSM in IDLE. Following full frame 0x23 -> decoded correctly.
- Glitch and reset:
  - 2-cycle low glitch on PS2_CLK (FILTER_LEN=4) mid-frame -> no extra bit shifted, frame 0x1B decodes correctly.
  - Reset asserted after bit 4 -> all outputs 0, no error strobe, next frame 0x1D decodes.
